// File: rtl/dsdaccel_sr_ctrl.sv
// dsdaccel_sr_ctrl: sequencer for the 17-stage row shift-register window buffer (clear, fill, shift, present windows).
// Define SR_CTRL_ZEROPAD_EN to make row 0 of every frame a zero pad row.
module dsdaccel_sr_ctrl #(
  parameter int NUM_ROWS  = 20,
  parameter int ROW_BYTES = 16
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic        i_START,
  input  logic        i_ABORT,
  input  logic        i_PIX_VALID,
  input  logic [7:0]  i_PIX_DATA,
  output logic        o_PIX_READY,
  output logic        o_BYTE_WE,
  output logic [3:0]  o_BYTE_ADDR,
  output logic [7:0]  o_BYTE_DIN,
  output logic        o_WORD_RST,
  output logic        o_WORD_WE,
  output logic [15:0] o_WORD_MASK,
  output logic        o_CHAIN_RST,
  output logic        o_CHAIN_SHIFT,
  output logic        o_WIN_VALID,
  input  logic        i_WIN_DONE,
  output logic [7:0]  o_WIN_IDX,
  output logic        o_BUSY,
  output logic        o_FRAME_DONE
);
  typedef enum logic [2:0] {IDLE, CLR, PAD, FILL, SHIFT, WIN, DONE} state_t;
  localparam logic [7:0] RESIDENT = 8'd16;
  localparam logic [7:0] LAST_ROW = 8'(NUM_ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(ROW_BYTES - 1);
`ifdef SR_CTRL_ZEROPAD_EN
  localparam state_t AFTER_CLR = PAD;
`else
  localparam state_t AFTER_CLR = FILL;
`endif
  state_t state, state_nx;
  logic [7:0] row_cnt, row_nx, win_idx, win_nx;
  logic [3:0] col_cnt, col_nx;
  logic fire;
  always_ff @(posedge i_CLK or negedge i_RST_n)
    if (!i_RST_n) begin
      state   <= IDLE;
      row_cnt <= '0;
      col_cnt <= '0;
      win_idx <= '0;
    end else begin
      state   <= state_nx;
      row_cnt <= row_nx;
      col_cnt <= col_nx;
      win_idx <= win_nx;
    end
  always_comb begin
    state_nx = state;
    row_nx   = row_cnt;
    col_nx   = col_cnt;
    win_nx   = win_idx;
    case (state)
      IDLE:  if (i_START) state_nx = CLR;
      CLR: begin
        row_nx   = '0;
        col_nx   = '0;
        win_nx   = '0;
        state_nx = AFTER_CLR;
      end
      PAD:   state_nx = SHIFT;
      FILL:  if (fire) begin
        col_nx = col_cnt + 4'd1;
        if (col_cnt == LAST_COL) state_nx = row_cnt < RESIDENT ? SHIFT : WIN;
      end
      SHIFT: begin
        row_nx   = row_cnt + 8'd1;
        state_nx = FILL;
      end
      WIN:   if (i_WIN_DONE) begin
        state_nx = row_cnt == LAST_ROW ? DONE : SHIFT;
        win_nx   = row_cnt == LAST_ROW ? win_idx : win_idx + 8'd1;
      end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // abort beats every other transition, including a start in IDLE
    if (i_ABORT) begin
      state_nx = IDLE;
      row_nx   = '0;
      col_nx   = '0;
      win_nx   = '0;
    end
  end
  assign o_PIX_READY   = state == FILL;
  assign fire          = i_PIX_VALID & o_PIX_READY;
  assign o_BYTE_WE     = fire;
  assign o_BYTE_ADDR   = col_cnt;
  assign o_BYTE_DIN    = o_PIX_READY ? i_PIX_DATA : '0;
  assign o_WORD_RST    = state == CLR;
  assign o_CHAIN_RST   = state == CLR;
  assign o_CHAIN_SHIFT = state == SHIFT;
  assign o_WIN_VALID   = state == WIN;
  assign o_WIN_IDX     = o_WIN_VALID ? win_idx : '0;
  assign o_BUSY        = state != IDLE;
  assign o_FRAME_DONE  = state == DONE;
`ifdef SR_CTRL_ZEROPAD_EN
  assign o_WORD_WE     = state == PAD;
  assign o_WORD_MASK   = {16{state == PAD}};
`else
  assign o_WORD_WE     = 1'b0;
  assign o_WORD_MASK   = '0;
`endif
endmodule

// File: tb/tb_dsdaccel_sr_ctrl.sv
// tb_dsdaccel_sr_ctrl: bench for dsdaccel_sr_ctrl; a phase/byte-count model of a frame is checked every cycle,
// with literal frame-level totals and latencies alongside. Honours SR_CTRL_ZEROPAD_EN.
module tb_dsdaccel_sr_ctrl;
  localparam int NR = 20;
`ifdef SR_CTRL_ZEROPAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif
  localparam int FIRST_LAT   = ZP ? 1 + 1 + 1 + 15 * 17 + 16 : 1 + 16 * 17 + 16;
  localparam int FRAME_BYTES = ZP ? (NR - 1) * 16 : NR * 16;
  localparam int M_IDLE = 0, M_CLR = 1, M_PAD = 2, M_FILL = 3, M_SHIFT = 4, M_WIN = 5, M_DONE = 6;
  logic i_CLK = 0, i_RST_n = 0, i_START = 0, i_ABORT = 0, i_PIX_VALID = 0;
  logic [7:0] i_PIX_DATA = 0;
  logic eng_done = 0, man_done = 0, i_WIN_DONE;
  logic o_PIX_READY, o_BYTE_WE, o_WORD_RST, o_WORD_WE, o_CHAIN_RST, o_CHAIN_SHIFT;
  logic o_WIN_VALID, o_BUSY, o_FRAME_DONE;
  logic [3:0] o_BYTE_ADDR;
  logic [7:0] o_BYTE_DIN, o_WIN_IDX;
  logic [15:0] o_WORD_MASK;
  bit pix_en = 0, rand_mode = 0, eng_en = 0;
  int ph, nb, ns;
  int n_chk = 0, n_fail = 0;
  int c_we = 0, c_sh = 0, c_fd = 0, c_win = 0;
  assign i_WIN_DONE = eng_done | man_done;
  always #5 i_CLK = ~i_CLK;
  dsdaccel_sr_ctrl #(.NUM_ROWS(NR), .ROW_BYTES(16)) dut (
    .i_CLK(i_CLK), .i_RST_n(i_RST_n), .i_START(i_START), .i_ABORT(i_ABORT),
    .i_PIX_VALID(i_PIX_VALID), .i_PIX_DATA(i_PIX_DATA), .o_PIX_READY(o_PIX_READY),
    .o_BYTE_WE(o_BYTE_WE), .o_BYTE_ADDR(o_BYTE_ADDR), .o_BYTE_DIN(o_BYTE_DIN),
    .o_WORD_RST(o_WORD_RST), .o_WORD_WE(o_WORD_WE), .o_WORD_MASK(o_WORD_MASK),
    .o_CHAIN_RST(o_CHAIN_RST), .o_CHAIN_SHIFT(o_CHAIN_SHIFT), .o_WIN_VALID(o_WIN_VALID),
    .i_WIN_DONE(i_WIN_DONE), .o_WIN_IDX(o_WIN_IDX), .o_BUSY(o_BUSY), .o_FRAME_DONE(o_FRAME_DONE)
  );
  // frame model: nb = bytes accepted this frame, ns = rows pushed into the chain
  always @(posedge i_CLK or negedge i_RST_n)
    if (!i_RST_n || i_ABORT) begin
      ph <= M_IDLE;
      nb <= 0;
      ns <= 0;
    end else
      case (ph)
        M_IDLE:  if (i_START) ph <= M_CLR;
        M_CLR:   begin nb <= 0; ns <= 0; ph <= ZP ? M_PAD : M_FILL; end
        M_PAD:   ph <= M_SHIFT;
        M_FILL:  if (i_PIX_VALID) begin
          nb <= nb + 1;
          if ((nb + 1) % 16 == 0) ph <= ns < 16 ? M_SHIFT : M_WIN;
        end
        M_SHIFT: begin ns <= ns + 1; ph <= M_FILL; end
        M_WIN:   if (i_WIN_DONE) ph <= ns == NR - 1 ? M_DONE : M_SHIFT;
        default: ph <= M_IDLE;
      endcase
  function automatic logic [44:0] exp_vec();
    logic f;
    f = ph == M_FILL;
    return {f, f & i_PIX_VALID, 4'(nb % 16), f ? i_PIX_DATA : 8'h00, ph == M_CLR, ph == M_PAD,
            ph == M_PAD ? 16'hFFFF : 16'h0000, ph == M_CLR, ph == M_SHIFT, ph == M_WIN,
            ph == M_WIN ? 8'(ns - 16) : 8'h00, ph != M_IDLE, ph == M_DONE};
  endfunction
  function automatic logic [44:0] got_vec();
    return {o_PIX_READY, o_BYTE_WE, o_BYTE_ADDR, o_BYTE_DIN, o_WORD_RST, o_WORD_WE, o_WORD_MASK,
            o_CHAIN_RST, o_CHAIN_SHIFT, o_WIN_VALID, o_WIN_IDX, o_BUSY, o_FRAME_DONE};
  endfunction
  task automatic check(string nm, longint got, longint expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, expv);
    end
  endtask
  task automatic tick();
    @(posedge i_CLK);
    #2;
  endtask
  task automatic settle();
    @(negedge i_CLK);
    #1;
  endtask
  initial forever begin
    @(posedge i_CLK);
    #2;
    i_PIX_VALID = pix_en && (!rand_mode || $urandom_range(0, 1) == 1);
    i_PIX_DATA  = i_PIX_DATA + 8'd1;
  end
  // engine model: releases each window on its third cycle
  initial begin
    int age = 0;
    forever begin
      @(posedge i_CLK);
      #2;
      if (eng_en && o_WIN_VALID) begin
        age++;
        eng_done = age == 3;
      end else begin
        age = 0;
        eng_done = 0;
      end
    end
  end
  task automatic run_frame(string nm, bit noise, bit check_lat);
    int we0, sh0, fd0, w0, k;
    we0 = c_we; sh0 = c_sh; fd0 = c_fd; w0 = c_win;
    i_START = 1;
    tick();
    i_START = 0;
    if (noise) begin
      repeat (20) tick();
      i_START = 1;
      man_done = 1;
      tick();
      i_START = 0;
      man_done = 0;
    end
    for (k = 1; k <= 3000; k++) begin
      settle();
      if (o_WIN_VALID) break;
    end
    check({nm, "_first_window_seen"}, o_WIN_VALID, 1);
    check({nm, "_first_window_idx"}, o_WIN_IDX, 0);
    if (check_lat) check({nm, "_first_window_latency"}, k - 1, FIRST_LAT);
    for (k = 0; k < 3000; k++) begin
      settle();
      if (o_FRAME_DONE) break;
    end
    check({nm, "_frame_done_seen"}, o_FRAME_DONE, 1);
    settle();
    check({nm, "_busy_after_done"}, o_BUSY, 0);
    check({nm, "_byte_writes"}, c_we - we0, FRAME_BYTES);
    check({nm, "_chain_shifts"}, c_sh - sh0, NR - 1);
    check({nm, "_windows"}, c_win - w0, NR - 16);
    check({nm, "_frame_done_pulses"}, c_fd - fd0, 1);
  endtask
  initial begin
    fork
      begin : cmp
        logic prev_wv = 0;
        forever begin
          @(negedge i_CLK);
          n_chk++;
          if (got_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL cycle_outputs at %0t: got %h, expected %h", $time, got_vec(), exp_vec());
          end
          c_we  += int'(o_BYTE_WE);
          c_sh  += int'(o_CHAIN_SHIFT);
          c_fd  += int'(o_FRAME_DONE);
          c_win += int'(o_WIN_VALID & !prev_wv);
          prev_wv = o_WIN_VALID;
        end
      end
      begin : stim
        int sh0, fd0;
        #1;
        check("reset_outputs", got_vec(), 0);
        repeat (3) tick();
        i_RST_n = 1;
        tick();
        check("idle_after_reset", o_BUSY, 0);
        pix_en = 1;
        eng_en = 1;
        run_frame("cont", 0, 1);
        rand_mode = 1;
        run_frame("gaps", 1, 0);
        rand_mode = 0;
        eng_en = 0;
        sh0 = c_sh;
        fd0 = c_fd;
        i_START = 1;
        tick();
        i_START = 0;
        for (int k = 0; k < 400 && !o_WIN_VALID; k++) settle();
        check("abort_reached_win", o_WIN_VALID, 1);
        check("abort_win_not_ready", o_PIX_READY, 0);
        tick();
        i_ABORT = 1;
        man_done = 1;
        tick();
        i_ABORT = 0;
        man_done = 0;
        settle();
        check("abort_busy", o_BUSY, 0);
        check("abort_no_frame_done", c_fd - fd0, 0);
        check("abort_no_extra_shift", c_sh - sh0, 16);
        tick();
        i_ABORT = 1;
        i_START = 1;
        tick();
        i_ABORT = 0;
        i_START = 0;
        settle();
        check("abort_beats_start", o_BUSY, 0);
        tick();
        i_START = 1;
        tick();
        i_START = 0;
        settle();
        check("restart_word_rst", o_WORD_RST, 1);
        check("restart_chain_rst", o_CHAIN_RST, 1);
        repeat (6) tick();
        check("pre_reset_in_fill", o_PIX_READY, 1);
        #1 i_RST_n = 0;
        #1;
        check("async_reset_outputs", got_vec(), 0);
        man_done = 1;
        repeat (3) tick();
        i_RST_n = 1;
        tick();
        man_done = 0;
        settle();
        check("idle_after_midfill_reset", o_BUSY, 0);
        pix_en = 0;
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
      begin : watchdog
        #1000000;
        n_fail++;
        $display("FAIL global_timeout at %0t: got no finish, expected finish", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    join_any
  end
endmodule
